// File: rtl/serial_slice_comparator.sv
// Serial WIDTH-bit magnitude comparator: 3-bit slices MSB first, all-equal falls back to l/e/g cascade.
// Optional SERIAL_CMP_EARLY_EXIT_EN: finish at the first unequal slice instead of always scanning N slices.
module serial_slice_comparator #(
  parameter int WIDTH = 12,
  parameter int CNT_W = $clog2(WIDTH/3)+1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             l,
  input  logic             e,
  input  logic             g,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int N = WIDTH/3;

  typedef enum logic [1:0] {IDLE, CMP, FIN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             l_q, e_q, g_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, done_q, lt_q, eq_q, gt_q;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
  logic             dec_q, dec_lt_q, dec_gt_q;
`endif

  logic [2:0] a_slices [N];
  logic [2:0] b_slices [N];
  logic [2:0] a_sl, b_sl;
  logic       sl_gt, sl_lt;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slice
      assign a_slices[gi] = a_q[3*gi +: 3];
      assign b_slices[gi] = b_q[3*gi +: 3];
    end
  endgenerate

  // Slice selected by the down-counter; the loop keeps index widths exact.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        a_sl = a_slices[i];
        b_sl = b_slices[i];
      end
    end
    sl_gt = (a_sl > b_sl);
    sl_lt = (a_sl < b_sl);
    cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      l_q      <= 1'b0;
      e_q      <= 1'b0;
      g_q      <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
      dec_q    <= 1'b0;
      dec_lt_q <= 1'b0;
      dec_gt_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        // FIN shares the accept path with IDLE so back-to-back starts work.
        IDLE, FIN: begin
          done_q <= 1'b0;
          if (start) begin
            a_q      <= A;
            b_q      <= B;
            l_q      <= l;
            e_q      <= e;
            g_q      <= g;
            cnt_q    <= CNT_W'(N-1);
            busy_q   <= 1'b1;
            state_q  <= CMP;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
            dec_q    <= 1'b0;
            dec_lt_q <= 1'b0;
            dec_gt_q <= 1'b0;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        CMP: begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
          if (sl_gt || sl_lt || cnt_q == '0) begin
            if (sl_gt || sl_lt) begin
              lt_q <= sl_lt;
              eq_q <= 1'b0;
              gt_q <= sl_gt;
            end else begin
              lt_q <= l_q;
              eq_q <= e_q;
              gt_q <= g_q;
            end
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            cnt_q <= cnt_d;
          end
`else
          if (cnt_q == '0) begin
            if (dec_q) begin
              lt_q <= dec_lt_q;
              eq_q <= 1'b0;
              gt_q <= dec_gt_q;
            end else if (sl_gt || sl_lt) begin
              lt_q <= sl_lt;
              eq_q <= 1'b0;
              gt_q <= sl_gt;
            end else begin
              lt_q <= l_q;
              eq_q <= e_q;
              gt_q <= g_q;
            end
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            // Only the most significant unequal slice decides; later slices are ignored.
            if (!dec_q && (sl_gt || sl_lt)) begin
              dec_q    <= 1'b1;
              dec_lt_q <= sl_lt;
              dec_gt_q <= sl_gt;
            end
            cnt_q <= cnt_d;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign lt   = lt_q;
  assign eq   = eq_q;
  assign gt   = gt_q;

endmodule

// File: tb/tb_serial_slice_comparator.sv
// Self-checking bench for serial_slice_comparator (WIDTH=12) using an expected-result queue.
module tb_serial_slice_comparator;

  localparam int WIDTH = 12;
  localparam int N     = WIDTH/3;
  localparam int TMO   = 20;

  logic              clk = 1'b0;
  logic              rst, start, l, e, g;
  logic [WIDTH-1:0]  A, B;
  logic              busy, done, lt, eq, gt;

  typedef struct {
    logic [2:0] res;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  serial_slice_comparator #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .l(l), .e(e), .g(g),
    .busy(busy), .done(done), .lt(lt), .eq(eq), .gt(gt)
  );

  always #5 clk = ~clk;

  // Whole-word reference: {lt,eq,gt}
  function automatic logic [2:0] model_res(input logic [WIDTH-1:0] a, b, input logic cl, ce, cg);
    if (a > b) return 3'b001;
    if (a < b) return 3'b100;
    return {cl, ce, cg};
  endfunction

  function automatic int model_lat(input logic [WIDTH-1:0] a, b);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int k = N-1; k >= 0; k--)
      if (a[3*k +: 3] != b[3*k +: 3]) return N - k;
`endif
    return N;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, b, input logic cl, ce, cg);
    exp_t x;
    A = a; B = b; l = cl; e = ce; g = cg; start = 1'b1;
    x.res = model_res(a, b, cl, ce, cg);
    x.lat = model_lat(a, b);
    sb.push_back(x);
    step();
    start = 1'b0;
  endtask

  // Waits (bounded) for done; cyc counts edges after the start edge.
  task automatic collect(output logic [2:0] res, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < TMO) begin
      step();
      cyc++;
    end
    res = {lt, eq, gt};
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; A = '0; B = '0; l = 0; e = 0; g = 0;
    step(); step();
    n_checks++;
    if ({busy, done, lt, eq, gt} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000", {busy, done, lt, eq, gt});
    end
    rst = 1'b0;
    step();
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: busy/done got %b want 00", {busy, done});
    end
    $display("test_reset done");
  endtask

  task automatic test_cascade();
    logic [2:0] lge_tab [4];
    logic [2:0] res, held;
    int cyc;
    exp_t x;
    lge_tab[0] = 3'b010; lge_tab[1] = 3'b100; lge_tab[2] = 3'b001; lge_tab[3] = 3'b111;
    for (int i = 0; i < 4; i++) begin
      issue(12'h249, 12'h249, lge_tab[i][2], lge_tab[i][1], lge_tab[i][0]);
      collect(res, cyc);
      x = sb.pop_front();
      n_checks++;
      if (res !== x.res) begin
        n_fail++;
        $display("FAIL cascade_res[%0d]: got %b want %b", i, res, x.res);
      end
      n_checks++;
      if (cyc !== x.lat) begin
        n_fail++;
        $display("FAIL cascade_lat[%0d]: got %0d want %0d", i, cyc, x.lat);
      end
      held = res;
      step();
      n_checks++;
      if ({done, lt, eq, gt} !== {1'b0, held}) begin
        n_fail++;
        $display("FAIL cascade_hold[%0d]: got done=%b res=%b want done=0 res=%b", i, done, {lt, eq, gt}, held);
      end
      $display("cascade lge=%b -> res=%b lat=%0d", lge_tab[i], res, cyc);
    end
  endtask

  task automatic test_msb_diff();
    logic [2:0] res;
    int cyc;
    exp_t x;
    issue(12'h400, 12'h200, 1'b0, 1'b1, 1'b0);
    collect(res, cyc);
    x = sb.pop_front();
    n_checks++;
    if (res !== 3'b001 || res !== x.res) begin
      n_fail++;
      $display("FAIL msb_res: got %b want 001", res);
    end
    n_checks++;
    if (cyc !== x.lat) begin
      n_fail++;
      $display("FAIL msb_lat: got %0d want %0d", cyc, x.lat);
    end
    $display("msb 400 vs 200 -> res=%b lat=%0d", res, cyc);
    step();
  endtask

  task automatic test_lsb_diff();
    logic [2:0] res;
    int cyc;
    exp_t x;
    issue(12'h001, 12'h002, 1'b0, 1'b0, 1'b1);
    collect(res, cyc);
    x = sb.pop_front();
    n_checks++;
    if (res !== 3'b100 || res !== x.res) begin
      n_fail++;
      $display("FAIL lsb_res: got %b want 100", res);
    end
    n_checks++;
    if (cyc !== N) begin
      n_fail++;
      $display("FAIL lsb_lat: got %0d want %0d", cyc, N);
    end
    $display("lsb 001 vs 002 -> res=%b lat=%0d", res, cyc);
    step();
  endtask

  task automatic test_busy_ignore();
    logic [2:0] res;
    int cyc;
    exp_t x;
    issue(12'h001, 12'h002, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_high: got %b want 1", busy);
    end
    A = 12'hFFF; B = 12'h000; l = 1'b0; e = 1'b0; g = 1'b1; start = 1'b1;
    step(); step();
    start = 1'b0;
    collect(res, cyc);
    cyc += 2;
    x = sb.pop_front();
    n_checks++;
    if (res !== x.res) begin
      n_fail++;
      $display("FAIL ignore_res: got %b want %b", res, x.res);
    end
    n_checks++;
    if (cyc !== x.lat) begin
      n_fail++;
      $display("FAIL ignore_lat: got %0d want %0d", cyc, x.lat);
    end
    step();
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL ignore_idle: busy/done got %b want 00", {busy, done});
    end
    $display("busy_ignore -> res=%b lat=%0d", res, cyc);
  endtask

  task automatic test_back_to_back();
    logic [2:0] res;
    int cyc;
    exp_t x;
    issue(12'h001, 12'h002, 1'b0, 1'b1, 1'b0);
    collect(res, cyc);
    x = sb.pop_front();
    n_checks++;
    if (res !== x.res || cyc !== x.lat) begin
      n_fail++;
      $display("FAIL b2b_first: got res=%b lat=%0d want res=%b lat=%0d", res, cyc, x.res, x.lat);
    end
    issue(12'h400, 12'h200, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({busy, done} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_accept: busy/done got %b want 10", {busy, done});
    end
    collect(res, cyc);
    x = sb.pop_front();
    n_checks++;
    if (res !== x.res || cyc !== x.lat) begin
      n_fail++;
      $display("FAIL b2b_second: got res=%b lat=%0d want res=%b lat=%0d", res, cyc, x.res, x.lat);
    end
    $display("back_to_back second -> res=%b lat=%0d", res, cyc);
    step();
  endtask

  task automatic test_reset_mid();
    logic [2:0] res;
    int cyc, seen;
    exp_t x;
    issue(12'h001, 12'h002, 1'b0, 1'b1, 1'b0);
    step();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, lt, eq, gt} !== 5'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %b want 00000", {busy, done, lt, eq, gt});
    end
    x = sb.pop_front();
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      step();
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL midreset_nodone: got %0d busy/done cycles want 0", seen);
    end
    issue(12'h001, 12'h002, 1'b0, 1'b1, 1'b0);
    collect(res, cyc);
    x = sb.pop_front();
    n_checks++;
    if (res !== x.res || cyc !== x.lat) begin
      n_fail++;
      $display("FAIL midreset_after: got res=%b lat=%0d want res=%b lat=%0d", res, cyc, x.res, x.lat);
    end
    $display("reset_mid then 001 vs 002 -> res=%b lat=%0d", res, cyc);
    step();
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b;
    logic [2:0] res, cas;
    int cyc;
    exp_t x;
    for (int i = 0; i < 12; i++) begin
      a = WIDTH'($urandom);
      b = a;
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 2) == 0) b[3*k +: 3] = 3'($urandom);
      cas = 3'($urandom);
      issue(a, b, cas[2], cas[1], cas[0]);
      collect(res, cyc);
      x = sb.pop_front();
      n_checks++;
      if (res !== x.res || cyc !== x.lat) begin
        n_fail++;
        $display("FAIL random[%0d]: A=%h B=%h lge=%b got res=%b lat=%0d want res=%b lat=%0d",
                 i, a, b, cas, res, cyc, x.res, x.lat);
      end
      $display("random A=%h B=%h lge=%b -> res=%b lat=%0d", a, b, cas, res, cyc);
      if (i % 2 == 0) step();
    end
  endtask

  initial begin
    test_reset();
    test_cascade();
    test_msb_diff();
    test_lsb_diff();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
